// File: rtl/battle_grid_controller_if.sv
// Signal bundle between the switch/button input layer and the battleship grid controller.
// Pure wiring, no latency; no backpressure: levels and one-shot buttons only.
// master drives the player inputs, slave is the controller driving the display and score.
interface battle_grid_controller_if #(
    parameter int COLS = 5,
    parameter int ROWS = 7
);
    logic                   onOff;
    logic                   status;
    logic                   save_game;
    logic                   attack_button;
    logic [COLS*ROWS-1:0]   board_in;
    logic [2:0]             columns_attack;
    logic [2:0]             rows_attack;
    logic [COLS*ROWS-1:0]   board_out;
    logic [5:0]             attacks_left;
    logic [6:0]             ships_left;
    logic                   game_over;
    logic                   win;
    logic                   err_pulse;

    modport master (
        output onOff, status, save_game, attack_button, board_in, columns_attack, rows_attack,
        input  board_out, attacks_left, ships_left, game_over, win, err_pulse
    );

    modport slave (
        input  onOff, status, save_game, attack_button, board_in, columns_attack, rows_attack,
        output board_out, attacks_left, ships_left, game_over, win, err_pulse
    );
endinterface

// File: rtl/battle_grid_controller.sv
// Battleship game controller: latches a layout, resolves strikes, drives the LED matrix.
// Latency: button state/score update 3 cycles after first sample, display 1 cycle later; switches 1+1.
// No backpressure: each synchronised button rising edge is acted on once or rejected with err_pulse.
module battle_grid_controller #(
    parameter int COLS        = 5,
    parameter int ROWS        = 7,
    parameter int MAX_ATTACKS = 10,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    battle_grid_controller_if.slave bus
);
    localparam int N  = COLS * ROWS;
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic [2:0] {S_OFF, S_PLACE, S_ATTACK, S_WIN, S_LOSE} state_t;

    state_t         state;
    logic [N-1:0]   layout, hit_mask, miss_mask, board_q, disp, tgt;
    logic [5:0]     att_left, att_dec;
    logic [6:0]     ships_q, ships_dec;
    logic           saved, err_q, win_q, over_q, place_err, place_err_q;
    logic [1:0]     save_sync, atk_sync;
    logic           save_prev, atk_prev, save_edge, atk_edge;
    logic [BW-1:0]  blink_cnt;
    logic           blink_ph;
    logic           in_grid, cell_marked, cell_ship;

    function automatic logic [6:0] popcount(input logic [N-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + {6'd0, v[i]};
        return c;
    endfunction

    always_comb begin
        in_grid     = (int'(bus.columns_attack) < COLS) && (int'(bus.rows_attack) < ROWS);
        tgt         = in_grid ? (N'(1) << (int'(bus.columns_attack) * ROWS + int'(bus.rows_attack))) : '0;
        cell_marked = |((hit_mask | miss_mask) & tgt);
        cell_ship   = |(layout & tgt);
        att_dec     = att_left - 6'd1;
        ships_dec   = ships_q - {6'd0, cell_ship};
        place_err   = bus.status & ~saved;
    end

    // Misses and the target cell blink in opposite phases so they stay distinguishable.
    always_comb begin
        disp = '0;
        case (state)
            S_PLACE:  disp = place_err ? '0 : bus.board_in;
            S_ATTACK: disp = hit_mask | (blink_ph ? miss_mask : '0) | (blink_ph ? '0 : tgt);
            S_WIN:    disp = blink_ph ? layout : '0;
            S_LOSE:   disp = layout;
            default:  disp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_OFF;
            layout      <= '0;
            hit_mask    <= '0;
            miss_mask   <= '0;
            board_q     <= '0;
            att_left    <= '0;
            ships_q     <= '0;
            saved       <= 1'b0;
            err_q       <= 1'b0;
            win_q       <= 1'b0;
            over_q      <= 1'b0;
            place_err_q <= 1'b0;
            save_sync   <= '0;
            atk_sync    <= '0;
            save_prev   <= 1'b0;
            atk_prev    <= 1'b0;
            save_edge   <= 1'b0;
            atk_edge    <= 1'b0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b1;
        end else begin
            save_sync   <= {save_sync[0], bus.save_game};
            atk_sync    <= {atk_sync[0], bus.attack_button};
            save_prev   <= save_sync[1];
            atk_prev    <= atk_sync[1];
            save_edge   <= save_sync[1] & ~save_prev;
            atk_edge    <= atk_sync[1] & ~atk_prev;
            board_q     <= disp;
            err_q       <= 1'b0;
            place_err_q <= 1'b0;

            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            if (!bus.onOff) begin
                state  <= S_OFF;
                win_q  <= 1'b0;
                over_q <= 1'b0;
            end else begin
                case (state)
                    S_OFF: state <= (bus.status && saved) ? S_ATTACK : S_PLACE;
                    S_PLACE: begin
                        // Report the unsaved-attack request once, not every cycle it persists.
                        place_err_q <= place_err;
                        if (place_err && !place_err_q) err_q <= 1'b1;
                        if (save_edge) begin
                            layout    <= bus.board_in;
                            hit_mask  <= '0;
                            miss_mask <= '0;
                            att_left  <= 6'(MAX_ATTACKS);
                            ships_q   <= popcount(bus.board_in);
                            saved     <= 1'b1;
                        end
                        if (bus.status && saved) state <= S_ATTACK;
                    end
                    S_ATTACK: begin
                        if (!bus.status) begin
                            state <= S_PLACE;
                        end else if (atk_edge) begin
                            if (!in_grid || cell_marked) begin
                                err_q <= 1'b1;
                            end else begin
                                hit_mask  <= hit_mask | (cell_ship ? tgt : '0);
                                miss_mask <= miss_mask | (cell_ship ? '0 : tgt);
                                att_left  <= att_dec;
                                ships_q   <= ships_dec;
                                // Sinking the last ship wins even on the final attack.
                                if (ships_dec == 7'd0) begin
                                    state  <= S_WIN;
                                    win_q  <= 1'b1;
                                    over_q <= 1'b1;
                                end else if (att_dec == 6'd0) begin
                                    state  <= S_LOSE;
                                    over_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        if (!bus.status) begin
                            state  <= S_PLACE;
                            win_q  <= 1'b0;
                            over_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.board_out    = board_q;
    assign bus.attacks_left = att_left;
    assign bus.ships_left   = ships_q;
    assign bus.game_over    = over_q;
    assign bus.win          = win_q;
    assign bus.err_pulse    = err_q;
endmodule

// File: tb/tb_battle_grid_controller.sv
// Randomized bench for battle_grid_controller against a game-rule reference model.
module tb_battle_grid_controller;
    localparam int COLS = 5, ROWS = 7, N = COLS * ROWS, MAXA = 10, BDIV = 4;
    localparam int M_OFF = 0, M_PLACE = 1, M_ATTACK = 2, M_WIN = 3, M_LOSE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;

    battle_grid_controller_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    battle_grid_controller #(.COLS(COLS), .ROWS(ROWS), .MAX_ATTACKS(MAXA), .BLINK_DIV(BDIV)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

    int         m_state, m_att, m_ships;
    bit         m_saved;
    bit [N-1:0] m_layout, m_hit, m_miss;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_cond();
        return (m_state == M_PLACE) && bus.status && !m_saved;
    endfunction

    function automatic void m_settle();
        repeat (3) begin
            if (!bus.onOff) m_state = M_OFF;
            else if (m_state == M_OFF) m_state = (bus.status && m_saved) ? M_ATTACK : M_PLACE;
            else if (m_state == M_PLACE) begin
                if (bus.status && m_saved) m_state = M_ATTACK;
            end else if (!bus.status) m_state = M_PLACE;
        end
    endfunction

    // Applies one button action to the model; returns whether it must be rejected.
    function automatic bit m_button(input bit s, input bit a);
        int c, r, idx;
        if (m_state == M_PLACE && s) begin
            m_layout = bus.board_in;
            m_hit = '0;
            m_miss = '0;
            m_att = MAXA;
            m_ships = $countones(bus.board_in);
            m_saved = 1'b1;
            return 1'b0;
        end
        if (m_state != M_ATTACK || !a) return 1'b0;
        c = int'(bus.columns_attack);
        r = int'(bus.rows_attack);
        if (c >= COLS || r >= ROWS) return 1'b1;
        idx = c * ROWS + r;
        if (m_hit[idx] || m_miss[idx]) return 1'b1;
        if (m_layout[idx]) begin
            m_hit[idx] = 1'b1;
            m_ships--;
        end else m_miss[idx] = 1'b1;
        m_att--;
        if (m_ships == 0) m_state = M_WIN;
        else if (m_att == 0) m_state = M_LOSE;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] exp_disp(input bit ph);
        bit [N-1:0] t;
        t = '0;
        if (bus.columns_attack < COLS && bus.rows_attack < ROWS)
            t[int'(bus.columns_attack) * ROWS + int'(bus.rows_attack)] = 1'b1;
        case (m_state)
            M_PLACE:  return m_cond() ? '0 : bus.board_in;
            M_ATTACK: return m_hit | (ph ? m_miss : '0) | (ph ? '0 : t);
            M_WIN:    return ph ? m_layout : '0;
            M_LOSE:   return m_layout;
            default:  return '0;
        endcase
    endfunction

    task automatic check_outputs();
        check_eq("attacks_left", bus.attacks_left, m_att);
        check_eq("ships_left", bus.ships_left, m_ships);
        check_eq("win", bus.win, m_state == M_WIN);
        check_eq("game_over", bus.game_over, m_state == M_WIN || m_state == M_LOSE);
    endtask

    task automatic check_display(input int n);
        bit ph;
        repeat (n) begin
            @(negedge clk);
            ph = (cyc == 0) ? 1'b1 : ((((cyc - 1) / BDIV) % 2) == 0);
            check_eq("board_out", bus.board_out, exp_disp(ph));
        end
    endtask

    task automatic sw_err(input bit old_cond);
        int e = 0;
        bit exp_e;
        exp_e = m_cond() && !old_cond;
        repeat (6) begin
            @(negedge clk);
            if (bus.err_pulse) e++;
        end
        check_eq("switch_err_pulses", e, exp_e);
    endtask

    task automatic set_sw(input bit on, input bit st);
        bit oc;
        oc = m_cond();
        @(negedge clk);
        bus.onOff = on;
        bus.status = st;
        m_settle();
        sw_err(oc);
    endtask

    task automatic press(input bit s, input bit a, input int hold);
        int errs = 0, epos = -1, att0, ships0;
        bit exp_e;
        att0 = m_att;
        ships0 = m_ships;
        exp_e = m_button(s, a);
        m_settle();
        @(negedge clk);
        bus.save_game = s;
        bus.attack_button = a;
        for (int i = 0; i < hold + 6; i++) begin
            @(negedge clk);
            if (i == hold - 1) begin
                bus.save_game = 1'b0;
                bus.attack_button = 1'b0;
            end
            if (bus.err_pulse) begin
                errs++;
                epos = i;
            end
            if (i == 2) check_eq("attacks_before_update", bus.attacks_left, att0);
            if (i == 3) begin
                check_eq("attacks_at_update", bus.attacks_left, m_att);
                check_eq("ships_at_update", bus.ships_left, m_ships);
            end
        end
        check_eq("button_err_pulses", errs, exp_e);
        if (exp_e) check_eq("err_pulse_cycle", epos, 3);
    endtask

    task automatic strike(input int c, input int r, input int hold);
        bus.columns_attack = 3'(c);
        bus.rows_attack = 3'(r);
        press(1'b0, 1'b1, hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_board_out", bus.board_out, 0);
        check_eq("rst_attacks_left", bus.attacks_left, 0);
        check_eq("rst_ships_left", bus.ships_left, 0);
        check_eq("rst_win", bus.win, 0);
        check_eq("rst_game_over", bus.game_over, 0);
        check_eq("rst_err_pulse", bus.err_pulse, 0);
        m_state = M_OFF;
        m_saved = 1'b0;
        m_layout = '0;
        m_hit = '0;
        m_miss = '0;
        m_att = 0;
        m_ships = 0;
        @(negedge clk);
        rst = 1'b1;
        m_settle();
        sw_err(1'b0);
    endtask

    task automatic new_game(input logic [N-1:0] layout, input bit both);
        set_sw(1'b1, 1'b0);
        bus.board_in = layout;
        press(1'b1, both, 2);
        check_outputs();
        set_sw(1'b1, 1'b1);
    endtask

    task automatic play_random();
        for (int it = 0; it < 300 && m_state == M_ATTACK; it++) begin
            if ($urandom_range(0, 15) == 0) begin
                set_sw(1'b0, 1'b1);
                check_display(2);
                set_sw(1'b1, 1'b1);
            end
            strike($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(1, 4));
        end
        check_eq("game_ended", (m_state == M_WIN || m_state == M_LOSE), 1);
        check_outputs();
        check_display(9);
    endtask

    initial begin
        logic [N-1:0] lay;
        bus.onOff = 1'b0;
        bus.status = 1'b0;
        bus.save_game = 1'b0;
        bus.attack_button = 1'b0;
        bus.board_in = '0;
        bus.columns_attack = '0;
        bus.rows_attack = '0;
        do_reset();
        check_display(3);

        // Attack mode requested with nothing saved.
        set_sw(1'b1, 1'b1);
        check_display(3);
        check_outputs();

        set_sw(1'b1, 1'b0);
        lay = '0;
        lay[0] = 1'b1;
        lay[8] = 1'b1;
        lay[34] = 1'b1;
        bus.board_in = lay;
        check_display(3);
        press(1'b1, 1'b0, 2);
        check_outputs();
        bus.board_in = N'({$urandom(), $urandom()});
        check_display(3);

        set_sw(1'b1, 1'b1);
        strike(0, 0, 2);
        check_outputs();
        check_display(10);
        strike(1, 0, 2);
        check_outputs();
        check_display(10);
        strike(0, 0, 2);
        strike(6, 0, 2);
        strike(0, 7, 1);
        strike(2, 2, 10);
        bus.columns_attack = 3'd3;
        bus.rows_attack = 3'd3;
        press(1'b1, 1'b1, 2);
        check_outputs();

        set_sw(1'b0, 1'b1);
        check_display(3);
        set_sw(1'b1, 1'b1);
        check_display(10);
        check_outputs();

        play_random();
        strike(4, 4, 2);
        check_outputs();

        // Win on the very last attack.
        lay = '0;
        lay[0] = 1'b1;
        new_game(lay, 1'b0);
        for (int i = 1; i <= MAXA - 1; i++) strike(i / ROWS, i % ROWS, 1);
        strike(0, 0, 1);
        check_outputs();
        check_display(10);

        new_game(lay, 1'b1);
        for (int i = 1; i <= MAXA; i++) strike(i / ROWS, i % ROWS, 2);
        check_outputs();
        check_display(10);

        new_game('0, 1'b0);
        strike(2, 3, 2);
        check_outputs();
        check_display(6);

        repeat (3) begin
            new_game(N'({$urandom(), $urandom()}), 1'b1);
            play_random();
        end

        // Reset in the middle of a game must also forget the saved layout.
        new_game(N'({$urandom(), $urandom()}) | N'(1), 1'b0);
        strike(1, 1, 2);
        strike(0, 0, 2);
        do_reset();
        check_display(3);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
